// File: rtl/acia_tx_arb.sv
// rtl/acia_tx_arb.sv - two-requester byte arbiter feeding a single transmitter holding register
module acia_tx_arb #(
  parameter int TO_WIDTH = 20
) (
  input  logic       PHI2,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic [7:0] DATA0,
  output logic       GNT0,
  input  logic       REQ1,
  input  logic [7:0] DATA1,
  output logic       GNT1,
  input  logic       PRIO,
  output logic [7:0] TXDATA,
  output logic       TXLATCH,
  input  logic       TXFULL,
  output logic       BUSY,
  output logic       ERR,
  input  logic       ERR_CLR
);

  typedef enum logic [1:0] {IDLE, WAIT_FULL, WAIT_EMPTY} state_t;

  state_t              state_q;
  logic [7:0]          txdata_q;
  logic                txlatch_q;
  logic                gnt0_q;
  logic                gnt1_q;
  logic                busy_q;
  logic                err_q;
  logic                last_q;
  logic [TO_WIDTH-1:0] cnt_q;

  logic                any_req;
  logic                win1;
  logic [TO_WIDTH-1:0] cnt_d;
  logic                to_hit;

  // last_q = 1 means requester 1 was granted most recently; a tie goes to the other one
  always_comb begin
    any_req = REQ0 | REQ1;
    win1    = PRIO ? REQ1 : (REQ1 & (~REQ0 | ~last_q));
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + TO_WIDTH'(1);
    to_hit  = (cnt_q != '1) && (cnt_d == '1);
  end

  always_ff @(posedge PHI2) begin
    if (RESET) begin
      state_q   <= IDLE;
      txdata_q  <= 8'h00;
      txlatch_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
    end else begin
      txlatch_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      if (ERR_CLR) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req && !TXFULL) begin
            txdata_q  <= win1 ? DATA1 : DATA0;
            txlatch_q <= 1'b1;
            gnt0_q    <= ~win1;
            gnt1_q    <= win1;
            last_q    <= win1;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= WAIT_FULL;
          end
        end
        WAIT_FULL: begin
          cnt_q <= cnt_d;
          if (to_hit) err_q <= 1'b1;
          if (TXFULL) state_q <= WAIT_EMPTY;
        end
        WAIT_EMPTY: begin
          cnt_q <= cnt_d;
          if (to_hit) err_q <= 1'b1;
          if (!TXFULL) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TXDATA  = txdata_q;
  assign TXLATCH = txlatch_q;
  assign GNT0    = gnt0_q;
  assign GNT1    = gnt1_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;

endmodule

// File: doc/acia_tx_arb.md
ACIA_TX_ARB -- requirements
Module: acia_tx_arb

Interface
REQ-001 The block SHALL have parameter TO_WIDTH, default 20, width of the drain-timeout counter.
REQ-002 PHI2  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 REQ0  input  1  requester 0 (CPU path) byte request.
REQ-005 DATA0  input  8  requester 0 byte, stable while REQ0 high.
REQ-006 GNT0  output  1  one-cycle grant to requester 0.
REQ-007 REQ1  input  1  requester 1 (flow-control/XON-XOFF path) byte request.
REQ-008 DATA1  input  8  requester 1 byte, stable while REQ1 high.
REQ-009 GNT1  output  1  one-cycle grant to requester 1.
REQ-010 PRIO  input  1  1 = requester 1 fixed priority; 0 = round-robin.
REQ-011 TXDATA  output  8  byte to transmitter holding register.
REQ-012 TXLATCH  output  1  one-cycle load strobe to transmitter.
REQ-013 TXFULL  input  1  transmitter holding register occupied.
REQ-014 BUSY  output  1  high whenever FSM not in IDLE.
REQ-015 ERR  output  1  sticky drain-timeout flag.
REQ-016 ERR_CLR  input  1  clears ERR.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_FULL, WAIT_EMPTY; all outputs registered.
REQ-018 IDLE: if (REQ0 or REQ1) and TXFULL=0, at that edge -> TXDATA <= winner's DATA, TXLATCH <= 1, GNTw <= 1, state WAIT_FULL; else stay.
REQ-019 IDLE with TXFULL=1 SHALL not grant regardless of requests.
REQ-020 TXLATCH and GNTx SHALL each be high exactly one cycle per grant; GNT0 and GNT1 never high together.
REQ-021 TXDATA SHALL hold its value until the next grant.
REQ-022 Arbitration, PRIO=1: REQ1 wins whenever asserted.
REQ-023 Arbitration, PRIO=0: sole requester wins; if both, the requester not granted last wins.
REQ-024 Last-granted register SHALL update on every grant (both PRIO modes).
REQ-025 WAIT_FULL: TXFULL=1 -> WAIT_EMPTY; else stay.
REQ-026 WAIT_EMPTY: TXFULL=0 -> IDLE; else stay.
REQ-027 Timeout counter (TO_WIDTH bits) SHALL clear on the grant edge, increment each cycle in WAIT_FULL/WAIT_EMPTY, saturate at all-ones.
REQ-028 Counter reaching all-ones SHALL set ERR; FSM keeps waiting (no re-latch, no abort).
REQ-029 ERR_CLR=1 SHALL clear ERR; if set and clear in same cycle, set wins.
REQ-030 Requester handshake: REQx held until GNTx; data captured on the GNTx edge; REQx dropped before grant SHALL cause no grant.
REQ-031 Minimum grant spacing: grant edge, >=1 WAIT_FULL cycle, >=1 WAIT_EMPTY cycle, then IDLE decision (>=4 cycles).
REQ-032 Requests arriving outside IDLE SHALL be ignored until IDLE; arbitration uses REQ values in the IDLE decision cycle.

Reset
REQ-033 RESET=1 at an edge SHALL force: state IDLE, TXDATA=0x00, TXLATCH=0, GNT0=0, GNT1=0, BUSY=0, ERR=0, counter=0, last-granted=requester 1.
REQ-034 RESET mid-operation (any state) SHALL abandon the transfer with no further TXLATCH/GNT until a new IDLE decision after RESET deasserts.
REQ-035 First tie after reset with PRIO=0 SHALL grant requester 0.

Verification
REQ-036 Single byte: REQ0=1, DATA0=0x41, TXFULL=0 -> next cycle TXLATCH=1, GNT0=1, TXDATA=0x41, BUSY=1; TXFULL 1 then 0 -> BUSY=0.
REQ-037 Round-robin: PRIO=0, REQ0=REQ1=1 continuously, DATA0=0xAA, DATA1=0x55 -> TXDATA sequence 0xAA,0x55,0xAA,0x55.
REQ-038 Priority: PRIO=1, both requesting for 3 transfers -> GNT1 three times, GNT0 never; drop REQ1 -> GNT0 next.
REQ-039 Blocked: TXFULL=1 in IDLE with REQ0=1 for 10 cycles -> no TXLATCH; TXFULL falls -> grant on following edge.
REQ-040 Timeout: TO_WIDTH=4, TXFULL stuck 1 after latch -> ERR=1 after 15 wait cycles, no second TXLATCH; ERR_CLR=1 -> ERR=0.
REQ-041 Reset mid-drain: RESET=1 in WAIT_EMPTY -> next cycle all outputs at reset values, TXDATA=0x00.
